// File: rtl/stdp_pkg.sv
// Shared types and saturating fixed-point helpers for the STDP synapse bank.
// The helpers work on a 32-bit carrier; callers zero-extend in and truncate out.
package stdp_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_DECIMAL_BITS = 8;
    localparam int ONE              = 1 << DEF_DECIMAL_BITS;
    localparam int MAX_VALUE        = (1 << DEF_WIDTH) - 1;
    localparam int FX_W             = 32;

    typedef logic [FX_W-1:0] fx_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACE,
        UPDATE,
        OUTPUT
    } state_e;

    function automatic fx_t sat_add(input fx_t a, input fx_t b, input fx_t max_v);
        logic [FX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[FX_W-1:0];
    endfunction

    function automatic fx_t sat_sub(input fx_t a, input fx_t b);
        return (b > a) ? '0 : a - b;
    endfunction

    // Full-width product, rescaled by the fractional bits, clipped to max_v.
    function automatic fx_t fx_mul(input fx_t a, input fx_t b, input int frac, input fx_t max_v);
        logic [2*FX_W-1:0] p;
        p = ({{FX_W{1'b0}}, a} * {{FX_W{1'b0}}, b}) >> frac;
        return (p > {{FX_W{1'b0}}, max_v}) ? max_v : p[FX_W-1:0];
    endfunction

endpackage

// File: rtl/stdp_trace.sv
// One exponentially decaying spike trace: on each strobe t <= t - (t>>TAU_SHIFT),
// plus ONE when the latched spike is set, saturating at all-ones.
module stdp_trace
    import stdp_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DECIMAL_BITS = DEF_DECIMAL_BITS,
    parameter int TAU_SHIFT    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             spike,
    output logic [WIDTH-1:0] trace
);

    localparam fx_t INC = fx_t'(1) << DECIMAL_BITS;
    localparam fx_t LIM = fx_t'({WIDTH{1'b1}});

    logic [WIDTH-1:0] trace_q, trace_d, decayed;

    always_comb begin
        decayed = trace_q - (trace_q >> TAU_SHIFT);
        trace_d = trace_q;
        if (en) begin
            trace_d = WIDTH'(sat_add(fx_t'(decayed), spike ? INC : '0, LIM));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trace_q <= '0;
        end else begin
            trace_q <= trace_d;
        end
    end

    assign trace = trace_q;

endmodule

// File: rtl/stdp_synapse_array.sv
// N_SYN-input pair-based STDP synapse bank with one shared multiplier and a summed current output.
// Optional homeostatic pull of weights toward W_INIT when STDP_WEIGHT_DECAY_EN is defined.
module stdp_synapse_array
    import stdp_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DECIMAL_BITS = DEF_DECIMAL_BITS,
    parameter int N_SYN        = 4,
    parameter int A_PLUS       = (1 << DECIMAL_BITS) >> 5,
    parameter int A_MINUS      = (1 << DECIMAL_BITS) >> 6,
    parameter int TAU_SHIFT    = 4,
    parameter int W_MAX        = (1 << DECIMAL_BITS) << 1,
    parameter int W_INIT       = 1 << DECIMAL_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [N_SYN-1:0]         pre_spikes,
    input  logic                     post_spike,
    input  logic                     learn_en,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [WIDTH-1:0]         i_syn_total,
    output logic [N_SYN*WIDTH-1:0]   weights,
    output logic [N_SYN*WIDTH-1:0]   debug_pre_trace,
    output logic [WIDTH-1:0]         debug_post_trace
);

    localparam int                  IDX_W    = (N_SYN > 1) ? $clog2(N_SYN) : 1;
    localparam fx_t                 LIM      = fx_t'({WIDTH{1'b1}});
    localparam logic signed [WIDTH+1:0] W_MAX_S = (WIDTH+2)'(W_MAX);
    localparam logic [WIDTH-1:0]    W_MAX_W  = WIDTH'(W_MAX);
    localparam logic [WIDTH-1:0]    W_INIT_W = WIDTH'(W_INIT);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [N_SYN-1:0]              pre_q, pre_d;
    logic                          post_q, post_d;
    logic                          learn_q, learn_d;
    logic [N_SYN-1:0][WIDTH-1:0]   w_q, w_d;
    logic [N_SYN-1:0][WIDTH-1:0]   pre_snap_q, pre_snap_d;
    logic [WIDTH-1:0]              ltd_q, ltd_d;
    logic [WIDTH-1:0]              isyn_q, isyn_d;

    logic [N_SYN-1:0][WIDTH-1:0]   pre_tr;
    logic [WIDTH-1:0]              post_tr;
    logic                          trace_en;

    logic [WIDTH-1:0]              mul_a, mul_b, mul_p;
    logic [WIDTH-1:0]              cur_w, ltp, ltd, w_new;
    logic signed [WIDTH+1:0]       w_sum;
`ifdef STDP_WEIGHT_DECAY_EN
    logic [WIDTH-1:0]              hd_step;
`endif

    // Traces advance once per sample, in the TRACE cycle, from the latched spikes.
    assign trace_en = (state_q == TRACE);

    for (genvar g = 0; g < N_SYN; g++) begin : g_pre
        stdp_trace #(
            .WIDTH        (WIDTH),
            .DECIMAL_BITS (DECIMAL_BITS),
            .TAU_SHIFT    (TAU_SHIFT)
        ) u_pre (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (trace_en),
            .spike   (pre_q[g]),
            .trace   (pre_tr[g])
        );
    end

    stdp_trace #(
        .WIDTH        (WIDTH),
        .DECIMAL_BITS (DECIMAL_BITS),
        .TAU_SHIFT    (TAU_SHIFT)
    ) u_post (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (trace_en),
        .spike   (post_q),
        .trace   (post_tr)
    );

    // LTD magnitude depends only on the post trace, so the single multiplier computes it
    // once in TRACE and is free for per-synapse LTP during the UPDATE sweep.
    always_comb begin
        mul_a = (state_q == TRACE) ? WIDTH'(A_MINUS) : WIDTH'(A_PLUS);
        mul_b = (state_q == TRACE) ? post_tr : pre_snap_q[idx_q];
        mul_p = WIDTH'(fx_mul(fx_t'(mul_a), fx_t'(mul_b), DECIMAL_BITS, LIM));
    end

    always_comb begin
        cur_w = w_q[idx_q];
        ltp   = (post_q && (pre_snap_q[idx_q] != '0)) ? mul_p : '0;
        ltd   = pre_q[idx_q] ? ltd_q : '0;
        w_sum = $signed({2'b00, cur_w}) + $signed({2'b00, ltp}) - $signed({2'b00, ltd});
        if (w_sum < 0) begin
            w_new = '0;
        end else if (w_sum > W_MAX_S) begin
            w_new = W_MAX_W;
        end else begin
            w_new = w_sum[WIDTH-1:0];
        end
`ifdef STDP_WEIGHT_DECAY_EN
        hd_step = '0;
        if (w_new > W_INIT_W) begin
            hd_step = (w_new - W_INIT_W) >> 8;
            if (hd_step == '0) hd_step = 1;
            w_new = w_new - hd_step;
        end else if (w_new < W_INIT_W) begin
            hd_step = (W_INIT_W - w_new) >> 8;
            if (hd_step == '0) hd_step = 1;
            w_new = w_new + hd_step;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pre_d      = pre_q;
        post_d     = post_q;
        learn_d    = learn_q;
        w_d        = w_q;
        pre_snap_d = pre_snap_q;
        ltd_d      = ltd_q;
        isyn_d     = isyn_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    pre_d   = pre_spikes;
                    post_d  = post_spike;
                    learn_d = learn_en;
                    state_d = TRACE;
                end
            end
            TRACE: begin
                pre_snap_d = pre_tr;
                ltd_d      = (post_tr != '0) ? mul_p : '0;
                isyn_d     = '0;
                idx_d      = '0;
                state_d    = UPDATE;
            end
            UPDATE: begin
                if (learn_q) w_d[idx_q] = w_new;
                if (pre_q[idx_q]) begin
                    isyn_d = WIDTH'(sat_add(fx_t'(isyn_q), fx_t'(cur_w), LIM));
                end
                if (idx_q == IDX_W'(N_SYN - 1)) begin
                    state_d = OUTPUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OUTPUT: begin
                if (ready_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pre_q      <= '0;
            post_q     <= 1'b0;
            learn_q    <= 1'b0;
            w_q        <= {N_SYN{W_INIT_W}};
            pre_snap_q <= '0;
            ltd_q      <= '0;
            isyn_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pre_q      <= pre_d;
            post_q     <= post_d;
            learn_q    <= learn_d;
            w_q        <= w_d;
            pre_snap_q <= pre_snap_d;
            ltd_q      <= ltd_d;
            isyn_q     <= isyn_d;
        end
    end

    assign ready_out        = (state_q == IDLE);
    assign valid_out        = (state_q == OUTPUT);
    assign i_syn_total      = isyn_q;
    assign weights          = w_q;
    assign debug_pre_trace  = pre_tr;
    assign debug_post_trace = post_tr;

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Randomized and directed bench for stdp_synapse_array against a per-sample behavioural model.
module tb_stdp_synapse_array;

    localparam int W = 16, N = 4, A_P = 8, A_M = 4, WMAX = 512, WINIT = 256, MAXV = 65535;

    logic           clk = 1'b0, reset_n = 1'b0;
    logic           valid_in = 1'b0, post_spike = 1'b0, learn_en = 1'b1, ready_in = 1'b1;
    logic [N-1:0]   pre_spikes = '0;
    logic           ready_out, valid_out;
    logic [W-1:0]   i_syn_total, debug_post_trace;
    logic [N*W-1:0] weights, debug_pre_trace;

    stdp_synapse_array dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .pre_spikes       (pre_spikes),
        .post_spike       (post_spike),
        .learn_en         (learn_en),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .i_syn_total      (i_syn_total),
        .weights          (weights),
        .debug_pre_trace  (debug_pre_trace),
        .debug_post_trace (debug_post_trace)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int m_w[N], m_pre[N], m_post, m_isyn;
    logic [W-1:0] obs_w[N], obs_pre[N], obs_post, obs_isyn;

    function automatic int sat(input int v, input int hi);
        return (v > hi) ? hi : ((v < 0) ? 0 : v);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_w[i] = WINIT;
            m_pre[i] = 0;
        end
        m_post = 0;
        m_isyn = 0;
    endfunction

    // One accepted sample, straight from the pair-based STDP rules.
    function automatic void model_step(input logic [N-1:0] pre, input logic post, input logic learn);
        int old_pre[N];
        int old_post, ltp, ltd, nw, d, st;
        old_pre = m_pre;
        old_post = m_post;
        m_isyn = 0;
        for (int i = 0; i < N; i++)
            if (pre[i]) m_isyn = sat(m_isyn + m_w[i], MAXV);
        for (int i = 0; i < N; i++) begin
            ltp = (post && old_pre[i] > 0) ? sat((A_P * old_pre[i]) / 256, MAXV) : 0;
            ltd = (pre[i] && old_post > 0) ? sat((A_M * old_post) / 256, MAXV) : 0;
            nw = sat(m_w[i] + ltp - ltd, WMAX);
`ifdef STDP_WEIGHT_DECAY_EN
            d = (nw > WINIT) ? nw - WINIT : WINIT - nw;
            st = (d / 256 == 0 && d != 0) ? 1 : d / 256;
            nw = (nw > WINIT) ? nw - st : nw + st;
`else
            d = 0;
            st = d;
`endif
            if (learn) m_w[i] = nw;
        end
        for (int i = 0; i < N; i++)
            m_pre[i] = sat(m_pre[i] - m_pre[i] / 16 + (pre[i] ? 256 : 0), MAXV);
        m_post = sat(m_post - m_post / 16 + (post ? 256 : 0), MAXV);
    endfunction

    task automatic capture();
        for (int i = 0; i < N; i++) begin
            obs_w[i] = weights[i*W +: W];
            obs_pre[i] = debug_pre_trace[i*W +: W];
        end
        obs_post = debug_post_trace;
        obs_isyn = i_syn_total;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Drives one sample through handshake and output transfer; captures the outputs.
    task automatic run_sample(input logic [N-1:0] pre, input logic post, input logic learn, input int stall);
        int t;
        @(negedge clk);
        valid_in = 1'b1; pre_spikes = pre; post_spike = post; learn_en = learn;
        ready_in = (stall == 0);
        t = 0;
        while (!ready_out && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL handshake_timeout got ready_out=0 need 1");
            valid_in = 1'b0;
            return;
        end
        @(negedge clk);
        valid_in = 1'b0;
        model_step(pre, post, learn);
        t = 0;
        while (!valid_out && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL valid_out_timeout got 0 need 1");
        end
        capture();
        repeat (stall) @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        capture();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_w[i] !== 16'd256) begin n_err++; $display("FAIL reset_w%0d got %0d need 256", i, obs_w[i]); end
            n_cmp++;
            if (obs_pre[i] !== 16'd0) begin n_err++; $display("FAIL reset_pre%0d got %0d need 0", i, obs_pre[i]); end
        end
        n_cmp++;
        if (obs_post !== 16'd0) begin n_err++; $display("FAIL reset_post got %0d need 0", obs_post); end
        n_cmp++;
        if (obs_isyn !== 16'd0) begin n_err++; $display("FAIL reset_isyn got %0d need 0", obs_isyn); end
        n_cmp++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            n_err++; $display("FAIL reset_hs got v=%b r=%b need v=0 r=1", valid_out, ready_out);
        end
    endtask

    task automatic test_latency_trace();
        do_reset();
        @(negedge clk);
        valid_in = 1'b1; pre_spikes = 4'b0001; post_spike = 1'b0; learn_en = 1'b1; ready_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            valid_in = 1'b0;
            n_cmp++;
            if (valid_out !== (k == 6)) begin
                n_err++; $display("FAIL latency_cycle%0d got valid_out=%b need %b", k, valid_out, k == 6);
            end
        end
        model_step(4'b0001, 1'b0, 1'b1);
        capture();
        n_cmp++;
        if (obs_isyn !== 16'd256) begin n_err++; $display("FAIL latency_isyn got %0d need 256", obs_isyn); end
        n_cmp++;
        if (obs_pre[0] !== 16'd256) begin n_err++; $display("FAIL latency_trace0 got %0d need 256", obs_pre[0]); end
        @(posedge clk);
        run_sample(4'b0000, 1'b0, 1'b1, 0);
        n_cmp++;
        if (obs_pre[0] !== 16'd240) begin n_err++; $display("FAIL decay1 got %0d need 240", obs_pre[0]); end
        run_sample(4'b0000, 1'b0, 1'b1, 0);
        n_cmp++;
        if (obs_pre[0] !== 16'd225) begin n_err++; $display("FAIL decay2 got %0d need 225", obs_pre[0]); end
    endtask

    task automatic test_ltp_ltd();
        int exp_a[N];
        int exp_b[N];
        exp_a = '{264, 256, 256, 256};
        exp_b = '{256, 252, 256, 256};
        do_reset();
        run_sample(4'b0001, 1'b0, 1'b1, 0);
        run_sample(4'b0000, 1'b1, 1'b1, 0);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_w[i] !== W'(exp_a[i])) begin n_err++; $display("FAIL ltp_w%0d got %0d need %0d", i, obs_w[i], exp_a[i]); end
        end
        do_reset();
        run_sample(4'b0000, 1'b1, 1'b1, 0);
        run_sample(4'b0010, 1'b0, 1'b1, 0);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_w[i] !== W'(exp_b[i])) begin n_err++; $display("FAIL ltd_w%0d got %0d need %0d", i, obs_w[i], exp_b[i]); end
        end
    endtask

    task automatic test_weight_bounds();
        do_reset();
        repeat (24) run_sample(4'b0001, 1'b1, 1'b1, 0);
        n_cmp++;
        if (obs_w[0] !== 16'd512) begin n_err++; $display("FAIL ceil_reach got %0d need 512", obs_w[0]); end
        repeat (3) run_sample(4'b0001, 1'b1, 1'b1, 0);
        n_cmp++;
        if (obs_w[0] !== 16'd512) begin n_err++; $display("FAIL ceil_hold got %0d need 512", obs_w[0]); end
        do_reset();
        // Post-only samples run with learning frozen so synapse 1 sees pure depression.
        for (int k = 0; k < 20; k++) begin
            run_sample(4'b0000, 1'b1, 1'b0, 0);
            run_sample(4'b0010, 1'b0, 1'b1, 0);
        end
        n_cmp++;
        if (obs_w[1] !== 16'd0) begin n_err++; $display("FAIL floor got %0d need 0", obs_w[1]); end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_w[i] !== W'(m_w[i])) begin n_err++; $display("FAIL floor_w%0d got %0d need %0d", i, obs_w[i], m_w[i]); end
        end
    endtask

    task automatic test_backpressure();
        int t;
        logic [W-1:0] exp_isyn;
        @(negedge clk);
        valid_in = 1'b1; pre_spikes = 4'b1011; post_spike = 1'b1; learn_en = 1'b1; ready_in = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        model_step(4'b1011, 1'b1, 1'b1);
        exp_isyn = W'(m_isyn);
        t = 0;
        while (!valid_out && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin n_cmp++; n_err++; $display("FAIL bp_timeout got valid_out=0 need 1"); end
        for (int k = 0; k < 10; k++) begin
            valid_in = 1'b1; pre_spikes = 4'($urandom_range(0, 15)); post_spike = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (valid_out !== 1'b1 || ready_out !== 1'b0 || i_syn_total !== exp_isyn) begin
                n_err++;
                $display("FAIL bp_hold%0d got v=%b r=%b isyn=%0d need v=1 r=0 isyn=%0d",
                         k, valid_out, ready_out, i_syn_total, exp_isyn);
            end
        end
        valid_in = 1'b0; ready_in = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            n_err++; $display("FAIL bp_release got v=%b r=%b need v=0 r=1", valid_out, ready_out);
        end
        run_sample(4'b0100, 1'b0, 1'b1, 0);
        n_cmp++;
        if (obs_isyn !== W'(m_isyn)) begin n_err++; $display("FAIL bp_next_isyn got %0d need %0d", obs_isyn, m_isyn); end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_pre[i] !== W'(m_pre[i])) begin n_err++; $display("FAIL bp_next_pre%0d got %0d need %0d", i, obs_pre[i], m_pre[i]); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        run_sample(4'b0001, 1'b0, 1'b1, 0);
        run_sample(4'b0000, 1'b1, 1'b1, 0);
        @(negedge clk);
        valid_in = 1'b1; pre_spikes = 4'b0011; post_spike = 1'b1; learn_en = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        capture();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_w[i] !== 16'd256 || obs_pre[i] !== 16'd0) begin
                n_err++; $display("FAIL midrst_syn%0d got w=%0d t=%0d need w=256 t=0", i, obs_w[i], obs_pre[i]);
            end
        end
        n_cmp++;
        if (obs_post !== 16'd0 || obs_isyn !== 16'd0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_state got post=%0d isyn=%0d v=%b r=%b need 0 0 0 1",
                     obs_post, obs_isyn, valid_out, ready_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        run_sample(4'b0001, 1'b0, 1'b1, 0);
        n_cmp++;
        if (obs_isyn !== 16'd256 || obs_pre[0] !== 16'd256) begin
            n_err++; $display("FAIL midrst_after got isyn=%0d t0=%0d need 256 256", obs_isyn, obs_pre[0]);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pre;
        logic post, learn;
        for (int s = 0; s < 40; s++) begin
            pre = N'($urandom_range(0, 15));
            post = 1'($urandom_range(0, 1));
            learn = ($urandom_range(0, 3) != 0);
            run_sample(pre, post, learn, $urandom_range(0, 3));
            n_cmp++;
            if (obs_isyn !== W'(m_isyn)) begin n_err++; $display("FAIL rand%0d_isyn got %0d need %0d", s, obs_isyn, m_isyn); end
            n_cmp++;
            if (obs_post !== W'(m_post)) begin n_err++; $display("FAIL rand%0d_post got %0d need %0d", s, obs_post, m_post); end
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (obs_w[i] !== W'(m_w[i])) begin n_err++; $display("FAIL rand%0d_w%0d got %0d need %0d", s, i, obs_w[i], m_w[i]); end
                n_cmp++;
                if (obs_pre[i] !== W'(m_pre[i])) begin n_err++; $display("FAIL rand%0d_pre%0d got %0d need %0d", s, i, obs_pre[i], m_pre[i]); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got running need finished");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_latency_trace();
        test_ltp_ltd();
        test_weight_bounds();
        test_backpressure();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
